// File: rtl/enc_led_sched.sv
// rtl/enc_led_sched.sv - quadrature/button decode, OFF/RUN/STEP mode FSM and rotating LED pattern
module enc_led_sched #(
  parameter int         DIV_BASE   = 1000,
  parameter int         DEB_CYCLES = 50000,
  parameter logic [7:0] PAT_INIT   = 8'b00000011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       btn,
  input  logic       ld,
  input  logic [7:0] ld_pat,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [2:0] speed_idx,
  output logic       dir,
  output logic       step_evt
);

  localparam int PW = $clog2(DIV_BASE * 128 + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    M_OFF  = 2'b00,
    M_RUN  = 2'b01,
    M_STEP = 2'b10,
    M_BAD  = 2'b11
  } mode_t;

  mode_t         st, st_nx;
  logic [1:0]    a_s, b_s, btn_s;
  logic          qa, qb, qa_dly;
  logic          deb;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] pre, pre_nx, term;
  logic [7:0]    pat, pat_nx;
  logic [2:0]    speed_nx;
  logic          detent, det_cw, det_eff;
  logic          btn_diff, deb_flip, btn_press;

  assign mode = st;

  function automatic logic [7:0] rot(input logic [7:0] p, input logic cw);
    return cw ? {p[6:0], p[7]} : {p[0], p[7:1]};
  endfunction

  always_comb begin
    detent    = qa & ~qa_dly;
    det_cw    = ~qb;
    btn_diff  = btn_s[1] != deb;
    deb_flip  = btn_diff && (deb_cnt == DEB_LAST);
    btn_press = deb_flip && btn_s[1];
    // A button press swallows any detent effect landing in the same cycle
    det_eff   = detent & ~btn_press;
    term      = (PW'(DIV_BASE) << (3'd7 - speed_idx)) - PW'(1);

    st_nx = st;
    case (st)
      M_OFF:   if (btn_press) st_nx = M_RUN;
      M_RUN:   if (btn_press) st_nx = M_STEP;
      M_STEP:  if (btn_press) st_nx = M_OFF;
      default: st_nx = M_OFF;
    endcase

    speed_nx = speed_idx;
    pat_nx   = pat;
    pre_nx   = '0;
    case (st)
      M_RUN: begin
        if (det_eff && det_cw && speed_idx != 3'd7)
          speed_nx = speed_idx + 3'd1;
        else if (det_eff && !det_cw && speed_idx != 3'd0)
          speed_nx = speed_idx - 3'd1;

        if (speed_nx != speed_idx) begin
          pre_nx = '0;
        end else if (pre == term) begin
          pre_nx = '0;
          pat_nx = rot(pat, dir);
        end else begin
          pre_nx = pre + PW'(1);
        end
      end
      M_STEP: if (det_eff) pat_nx = rot(pat, det_cw);
      default: ;
    endcase

    if (st_nx != M_RUN) pre_nx = '0;
    if (ld) pat_nx = (ld_pat == 8'd0) ? PAT_INIT : ld_pat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_s       <= '0;
      b_s       <= '0;
      btn_s     <= '0;
      qa        <= 1'b0;
      qb        <= 1'b0;
      qa_dly    <= 1'b0;
      deb       <= 1'b0;
      deb_cnt   <= '0;
      pre       <= '0;
      pat       <= PAT_INIT;
      st        <= M_OFF;
      speed_idx <= 3'd3;
      dir       <= 1'b1;
      step_evt  <= 1'b0;
      led       <= 8'd0;
    end else begin
      a_s   <= {a_s[0], enc_a};
      b_s   <= {b_s[0], enc_b};
      btn_s <= {btn_s[0], btn};

      case ({a_s[1], b_s[1]})
        2'b00: qa <= 1'b0;
        2'b11: qa <= 1'b1;
        2'b01: qb <= 1'b1;
        2'b10: qb <= 1'b0;
        default: ;
      endcase
      qa_dly <= qa;

      deb_cnt <= (!btn_diff || deb_flip) ? '0 : deb_cnt + DW'(1);
      if (deb_flip) deb <= btn_s[1];

      step_evt <= detent;
      if (detent) dir <= det_cw;

      st        <= st_nx;
      speed_idx <= speed_nx;
      pre       <= pre_nx;
      pat       <= pat_nx;
      led       <= (st_nx == M_OFF) ? 8'd0 : pat_nx;
    end
  end

endmodule
